// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin front end sharing one 32-bit funnel shifter
module shift_funnel (
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [5:0]  amt,
  output logic [31:0] y
);
  assign y = 32'({hi, lo} >> amt);
endmodule

module shift_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [4:0]       req0_shamt,
  input  logic [1:0]       req0_f,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [4:0]       req1_shamt,
  input  logic [1:0]       req1_f,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag
);
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_y_q, rsp_y_d;
  logic             rsp_src_q, rsp_src_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             prio_q, prio_d;

  logic             stage_free;
  logic             grant0, grant1;
  logic             acc0, acc1;
  logic [31:0]      sel_a;
  logic [4:0]       sel_shamt;
  logic [1:0]       sel_f;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      fun_hi, fun_lo, fun_y;
  logic [5:0]       fun_amt;

  assign stage_free = ~rsp_valid_q | rsp_ready;
  assign grant0     = req0_valid & (~req1_valid | ~prio_q);
  assign grant1     = req1_valid & (~req0_valid |  prio_q);
  assign req0_ready = ~reset & stage_free & grant0;
  assign req1_ready = ~reset & stage_free & grant1;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  assign sel_a     = grant1 ? req1_a     : req0_a;
  assign sel_shamt = grant1 ? req1_shamt : req0_shamt;
  assign sel_f     = grant1 ? req1_f     : req0_f;
  assign sel_tag   = grant1 ? req1_tag   : req0_tag;

  // Left shifts take the high half {a,0} down by 32-shamt; right shifts take {fill,a} down by shamt.
  always_comb begin
    fun_hi  = '0;
    fun_lo  = '0;
    fun_amt = '0;
    case (sel_f)
      2'b01: begin
        fun_hi  = '0;
        fun_lo  = sel_a;
        fun_amt = {1'b0, sel_shamt};
      end
      2'b11: begin
        fun_hi  = {32{sel_a[31]}};
        fun_lo  = sel_a;
        fun_amt = {1'b0, sel_shamt};
      end
      default: begin
        fun_hi  = sel_a;
        fun_lo  = '0;
        fun_amt = 6'd32 - {1'b0, sel_shamt};
      end
    endcase
  end

  shift_funnel u_funnel (
    .hi  (fun_hi),
    .lo  (fun_lo),
    .amt (fun_amt),
    .y   (fun_y)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_src_d   = rsp_src_q;
    rsp_tag_d   = rsp_tag_q;
    prio_d      = prio_q;
    if (acc0 | acc1) begin
      rsp_valid_d = 1'b1;
      rsp_y_d     = fun_y;
      rsp_src_d   = acc1;
      rsp_tag_d   = sel_tag;
      prio_d      = acc0;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_src_q   <= 1'b0;
      rsp_tag_q   <= '0;
      prio_q      <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_src_q   <= rsp_src_d;
      rsp_tag_q   <= rsp_tag_d;
      prio_q      <= prio_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_src   = rsp_src_q;
  assign rsp_tag   = rsp_tag_q;
endmodule
